// File: rtl/led_matrix_scan_ctrl.sv
// led_matrix_scan_ctrl
// Scan controller and two-source arbiter for an 8x8 LED matrix.
// A whole frame is copied into a shadow buffer once per refresh (LOAD), then
// shown row by row (SHOW) with blanking between rows (BLANK), all on clk.
// Optional build macro: LED_DIM_EN adds a 3-bit 'bright' input that shortens
// the lit part of each SHOW dwell.
//
// state | meaning
// ------+-------------------------------------------------------------
// LOAD  | one cycle: arbitrate, latch winner's frame, pulse frame_start
// SHOW  | ROW_TICKS cycles: row S driven from the shadow buffer
// BLANK | BLANK_TICKS cycles: display off, S advances on the last cycle
//
// Every output is a flop loaded from the decode of the current state, so the
// visible outputs trail the state register by one cycle. For example, the
// frame_start/ack pulse becomes visible in the cycle after the LOAD edge, and
// row 0 data appears one cycle after that.

module led_matrix_scan_ctrl #(
  parameter int ROW_TICKS   = 50000,
  parameter int BLANK_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        src0_req,
  input  logic [63:0] src0_frame,
  output logic        src0_ack,
  input  logic        src1_req,
  input  logic [63:0] src1_frame,
  output logic        src1_ack,
  output logic [2:0]  S,
  output logic        En,
  output logic [7:0]  DATA_R,
  output logic [7:0]  DATA_G,
  output logic [7:0]  DATA_B,
  output logic        frame_start,
  output logic        cur_src
`ifdef LED_DIM_EN
  ,
  input  logic [2:0]  bright
`endif
);

  localparam int ROW_W   = $clog2(ROW_TICKS) + 1;
  localparam int BLANK_W = $clog2(BLANK_TICKS) + 1;
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROW_TICKS - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_TICKS - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t             state, state_d;
  logic [ROW_W-1:0]   row_cnt, row_cnt_d;
  logic [BLANK_W-1:0] blank_cnt, blank_cnt_d;
  logic [63:0]        shadow, shadow_d;
  logic               cur_src_d;
  logic [2:0]         s_d;
  logic               en_d;
  logic [7:0]         data_r_d;
  logic               frame_start_d;
  logic               ack0_d, ack1_d;
  logic [7:0]         row_bits;
  logic               lit;

`ifdef LED_DIM_EN
  logic [2:0]  bright_q, bright_d;
  logic [31:0] dim_limit;

  // Lit portion of the dwell: ((bright+1)*ROW_TICKS)/8, bright=7 -> whole dwell.
  always_comb begin
    dim_limit = ((32'(bright_q) + 32'd1) * 32'(ROW_TICKS)) >> 3;
    lit       = (32'(row_cnt) < dim_limit);
  end
`else
  // Without dimming the row is lit for the whole dwell.
  always_comb begin
    lit = 1'b1;
  end
`endif

  // Current row of the shadow frame selected by the row counter S.
  always_comb begin
    row_bits = shadow[{S, 3'b000} +: 8];
  end

  // State register and dwell counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= LOAD;
      row_cnt   <= '0;
      blank_cnt <= '0;
    end else begin
      state     <= state_d;
      row_cnt   <= row_cnt_d;
      blank_cnt <= blank_cnt_d;
    end
  end

  // Next-state, shadow load and next-output decode.
  always_comb begin
    state_d       = state;
    row_cnt_d     = '0;
    blank_cnt_d   = '0;
    shadow_d      = shadow;
    cur_src_d     = cur_src;
    s_d           = S;
    en_d          = 1'b0;
    data_r_d      = 8'hFF;
    frame_start_d = 1'b0;
    ack0_d        = 1'b0;
    ack1_d        = 1'b0;
`ifdef LED_DIM_EN
    bright_d      = bright_q;
`endif
    case (state)
      LOAD: begin
        frame_start_d = 1'b1;
        s_d           = 3'd0;
        state_d       = SHOW;
`ifdef LED_DIM_EN
        bright_d      = bright;
`endif
        // Overlay wins ties; with no request the old frame simply repeats.
        if (src1_req) begin
          shadow_d  = src1_frame;
          cur_src_d = 1'b1;
          ack1_d    = 1'b1;
        end else if (src0_req) begin
          shadow_d  = src0_frame;
          cur_src_d = 1'b0;
          ack0_d    = 1'b1;
        end
      end
      SHOW: begin
        en_d     = lit;
        data_r_d = lit ? ~row_bits : 8'hFF;
        if (row_cnt == ROW_LAST) begin
          state_d = BLANK;
        end else begin
          row_cnt_d = row_cnt + 1'b1;
        end
      end
      BLANK: begin
        if (blank_cnt == BLANK_LAST) begin
          if (S == 3'd7) begin
            state_d = LOAD;
          end else begin
            s_d     = S + 3'd1;
            state_d = SHOW;
          end
        end else begin
          blank_cnt_d = blank_cnt + 1'b1;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // Shadow frame and its source tag; only LOAD ever changes them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow  <= '0;
      cur_src <= 1'b0;
    end else begin
      shadow  <= shadow_d;
      cur_src <= cur_src_d;
    end
  end

`ifdef LED_DIM_EN
  // Brightness is frozen for the frame at LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bright_q <= 3'd0;
    end else begin
      bright_q <= bright_d;
    end
  end
`endif

  // Registered matrix drive, handshake and frame marker outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      S           <= 3'd0;
      En          <= 1'b0;
      DATA_R      <= 8'hFF;
      frame_start <= 1'b0;
      src0_ack    <= 1'b0;
      src1_ack    <= 1'b0;
    end else begin
      S           <= s_d;
      En          <= en_d;
      DATA_R      <= data_r_d;
      frame_start <= frame_start_d;
      src0_ack    <= ack0_d;
      src1_ack    <= ack1_d;
    end
  end

  // Green and blue are unused and held dark.
  always_comb begin
    DATA_G = 8'hFF;
    DATA_B = 8'hFF;
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Bench for led_matrix_scan_ctrl with ROW_TICKS=4, BLANK_TICKS=1 (41-cycle frame).
// Frames offered to the DUT are queued with their expected source; each ack
// pops one entry and the following frame is compared cycle by cycle against
// a timing model of the scan.
module tb_led_matrix_scan_ctrl;
  localparam int RT = 4;
  localparam int BT = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        src0_req = 1'b0;
  logic [63:0] src0_frame = '0;
  logic        src1_req = 1'b0;
  logic [63:0] src1_frame = '0;
  logic        src0_ack, src1_ack, En, frame_start, cur_src;
  logic [2:0]  S;
  logic [7:0]  DATA_R, DATA_G, DATA_B;
`ifdef LED_DIM_EN
  logic [2:0]  bright = 3'd7;
`endif

  always #5 clk = ~clk;

  led_matrix_scan_ctrl #(.ROW_TICKS(RT), .BLANK_TICKS(BT)) dut (
    .clk(clk), .reset_n(reset_n),
    .src0_req(src0_req), .src0_frame(src0_frame), .src0_ack(src0_ack),
    .src1_req(src1_req), .src1_frame(src1_frame), .src1_ack(src1_ack),
    .S(S), .En(En), .DATA_R(DATA_R), .DATA_G(DATA_G), .DATA_B(DATA_B),
    .frame_start(frame_start), .cur_src(cur_src)
`ifdef LED_DIM_EN
    , .bright(bright)
`endif
  );

  typedef struct {
    logic        src;
    logic [63:0] frame;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          total = 0;
  int          bad = 0;
  int          n;
  logic [13:0] cap[0:41];
  logic [13:0] ev;
  logic [63:0] shown = '0;
  wire  [13:0] obs = {frame_start, S, En, DATA_R, src0_ack, src1_ack};

  // Expected {frame_start,S,En,DATA_R,ack0,ack1} k cycles after a frame_start.
  function automatic logic [13:0] exp_vec(input logic [63:0] f, input int k,
                                          input int nl, input logic a0, input logic a1);
    logic [2:0] s;
    logic       en;
    logic [7:0] dr;
    int         j, r, p;
    if (k == 0 || k == 41) return {1'b1, 3'd0, 1'b0, 8'hFF, a0, a1};
    j  = k - 1;
    r  = j / 5;
    p  = j % 5;
    en = 1'b0;
    dr = 8'hFF;
    if (p < 4) begin
      s  = r[2:0];
      en = (p < nl);
      dr = en ? ~f[8*r +: 8] : 8'hFF;
    end else begin
      s = (r < 7) ? 3'(r + 1) : 3'd7;
    end
    return {1'b0, s, en, dr, 2'b00};
  endfunction

  task automatic capture_frame();
    cap[0] = obs;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk);
      cap[k] = obs;
    end
  endtask

  task automatic wait_fs(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (frame_start !== 1'b1 && cnt < 100);
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({S, En, DATA_R, DATA_G, DATA_B} !== {3'd0, 1'b0, 24'hFFFFFF}) begin
      bad++;
      $display("FAIL reset_drive got=%h want=%h", {S, En, DATA_R, DATA_G, DATA_B},
               {3'd0, 1'b0, 24'hFFFFFF});
    end
    total++;
    if ({frame_start, src0_ack, src1_ack, cur_src} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=0000", {frame_start, src0_ack, src1_ack, cur_src});
    end
    reset_n = 1'b1;
    wait_fs(n);
    total++;
    if (frame_start !== 1'b1 || n != 1) begin
      bad++;
      $display("FAIL reset_first_load got=cycles %0d fs %b want=cycles 1 fs 1", n, frame_start);
    end
    total++;
    if ({src0_ack, src1_ack, S, En, DATA_R} !== {2'b00, 3'd0, 1'b0, 8'hFF}) begin
      bad++;
      $display("FAIL reset_load_out got=%h want=%h", {src0_ack, src1_ack, S, En, DATA_R},
               {2'b00, 3'd0, 1'b0, 8'hFF});
    end
  endtask

  task automatic test_idle();
    capture_frame();
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(64'd0, k, RT, 1'b0, 1'b0);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL idle_frame k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
  endtask

  task automatic test_src0();
    src0_frame = 64'h0000_0000_0000_00A5;
    src0_req   = 1'b1;
    sb.push_back('{1'b0, 64'h0000_0000_0000_00A5});
    wait_fs(n);
    total++;
    if ({frame_start, src0_ack, src1_ack} !== 3'b110) begin
      bad++;
      $display("FAIL src0_ack got=%b want=110", {frame_start, src0_ack, src1_ack});
    end
    src0_req = 1'b0;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL src0_sb got=empty want=entry");
    end else begin
      e = sb.pop_front();
      total++;
      if (cur_src !== e.src) begin
        bad++;
        $display("FAIL src0_cur_src got=%b want=%b", cur_src, e.src);
      end
      shown = e.frame;
    end
    capture_frame();
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(shown, k, RT, 1'b0, 1'b0);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL src0_frame k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
  endtask

  task automatic test_priority();
    src0_frame = 64'h1122_3344_5566_7788;
    src1_frame = 64'h0000_0000_0F00_0000;
    src0_req   = 1'b1;
    src1_req   = 1'b1;
    sb.push_back('{1'b1, 64'h0000_0000_0F00_0000});
    sb.push_back('{1'b1, 64'h0000_0000_0F00_0000});
    wait_fs(n);
    total++;
    if ({frame_start, src0_ack, src1_ack} !== 3'b101) begin
      bad++;
      $display("FAIL prio_ack got=%b want=101", {frame_start, src0_ack, src1_ack});
    end
    e = sb.pop_front();
    total++;
    if (cur_src !== e.src) begin
      bad++;
      $display("FAIL prio_cur_src got=%b want=%b", cur_src, e.src);
    end
    shown = e.frame;
    // Both held: the overlay is re-latched and src0 starves.
    capture_frame();
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(shown, k, RT, 1'b0, 1'b1);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL prio_frame1 k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
    e = sb.pop_front();
    total++;
    if (cur_src !== e.src) begin
      bad++;
      $display("FAIL prio_relatch got=%b want=%b", cur_src, e.src);
    end
    src1_req = 1'b0;
    sb.push_back('{1'b0, 64'h1122_3344_5566_7788});
    capture_frame();
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(shown, k, RT, 1'b1, 1'b0);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL prio_frame2 k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
    src0_req = 1'b0;
    e = sb.pop_front();
    total++;
    if (cur_src !== e.src) begin
      bad++;
      $display("FAIL prio_src0_late got=%b want=%b", cur_src, e.src);
    end
    shown = e.frame;
  endtask

  task automatic test_shadow_hold();
    logic [63:0] old_frame;
    old_frame = shown;
    fork
      capture_frame();
      begin
        repeat (21) @(negedge clk);
        src0_frame = 64'hDEAD_BEEF_0123_4567;
        src0_req   = 1'b1;
        sb.push_back('{1'b0, 64'hDEAD_BEEF_0123_4567});
      end
    join
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(old_frame, k, RT, 1'b1, 1'b0);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL hold_frame k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
    src0_req = 1'b0;
    e = sb.pop_front();
    total++;
    if (cur_src !== e.src) begin
      bad++;
      $display("FAIL hold_cur_src got=%b want=%b", cur_src, e.src);
    end
    shown = e.frame;
    capture_frame();
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(shown, k, RT, 1'b0, 1'b0);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL hold_new k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (26) @(negedge clk);
    total++;
    if (S !== 3'd5 || En !== 1'b1) begin
      bad++;
      $display("FAIL midrst_pre got=S%0d En%b want=S5 En1", S, En);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if ({S, En, DATA_R, frame_start, cur_src} !== {3'd0, 1'b0, 8'hFF, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL midrst_async got=%h want=%h", {S, En, DATA_R, frame_start, cur_src},
               {3'd0, 1'b0, 8'hFF, 1'b0, 1'b0});
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_fs(n);
    total++;
    if (frame_start !== 1'b1 || n != 1) begin
      bad++;
      $display("FAIL midrst_load got=cycles %0d fs %b want=cycles 1 fs 1", n, frame_start);
    end
    shown = 64'd0;
    capture_frame();
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(shown, k, RT, 1'b0, 1'b0);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL midrst_frame k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
  endtask

`ifdef LED_DIM_EN
  task automatic test_dim();
    int nl;
    bright     = 3'd1;
    src0_frame = 64'hFF00_FF00_FF00_FF00;
    src0_req   = 1'b1;
    sb.push_back('{1'b0, 64'hFF00_FF00_FF00_FF00});
    wait_fs(n);
    total++;
    if ({frame_start, src0_ack} !== 2'b11) begin
      bad++;
      $display("FAIL dim_ack got=%b want=11", {frame_start, src0_ack});
    end
    src0_req = 1'b0;
    e = sb.pop_front();
    shown = e.frame;
    nl = ((1 + 1) * RT) >> 3;
    capture_frame();
    bright = 3'd7;
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(shown, k, nl, 1'b0, 1'b0);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL dim_b1 k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
    nl = ((7 + 1) * RT) >> 3;
    wait_fs(n);
    capture_frame();
    for (int k = 1; k <= 41; k++) begin
      ev = exp_vec(shown, k, nl, 1'b0, 1'b0);
      total++;
      if (cap[k] !== ev) begin
        bad++;
        $display("FAIL dim_b7 k=%0d got=%h want=%h", k, cap[k], ev);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_src0();
    test_priority();
    test_shadow_hold();
    test_reset_mid();
`ifdef LED_DIM_EN
    test_dim();
`endif
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
